fetch_pc: RTL and testbench
===========================

# fetch_pc

Program-counter and fetch-sequencing stage sitting directly upstream of the instruction memory. Holds the PC_BITS-wide program counter that addresses instruction memory, and advances it by +1, redirects it through an internal branch-target lookup table, holds it on stall, or freezes it on halt. Provides start/done sequencing for a program run and a count of executed instructions.

## Interface
- PC_BITS, 12, width of the program counter (matches instruction-memory address width)
- LUT_IDX_BITS, 3, index width of the branch-target LUT (2**LUT_IDX_BITS entries)
- CNT_BITS, 16, width of the executed-instruction counter
- START_ADDR, 0, PC value loaded when a run starts
- clk  in  1  single system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; dominates every other input
- start  in  1  begin a run; accepted only in IDLE or HALTED
- stall  in  1  hold PC this cycle (RUN only)
- halt  in  1  current instruction is a halt (from decode)
- branch_taken  in  1  redirect PC to LUT[branch_idx]
- branch_idx  in  LUT_IDX_BITS  LUT entry selecting the branch target (decode reg field)
- lut_we  in  1  write enable for the branch-target LUT
- lut_waddr  in  LUT_IDX_BITS  LUT write index
- lut_wdata  in  PC_BITS  LUT write data (absolute target address)
- pc  out  PC_BITS  registered address to instruction memory
- pc_valid  out  1  high only in RUN
- done  out  1  high only in HALTED
- instr_count  out  CNT_BITS  instructions executed in current/last run

## Operation
- States: IDLE, RUN, HALTED; state register encodes them, outputs are decoded from state and registers only (no combinational input-to-output path).
- Reset (any state): state=IDLE, pc=START_ADDR, instr_count=0, all LUT entries=0, pc_valid=0, done=0.
- IDLE: pc held at START_ADDR. start=1 -> RUN, pc=START_ADDR, instr_count=0.
- RUN, priority per edge: halt > stall > branch_taken > increment.
  - halt=1 (regardless of stall): -> HALTED; pc unchanged; instr_count +1 (halt counts as executed).
  - stall=1: pc, instr_count unchanged; branch_taken ignored.
  - branch_taken=1: pc=LUT[branch_idx]; instr_count +1.
  - otherwise: pc=pc+1 modulo 2**PC_BITS (all-ones wraps to 0, no flag); instr_count +1.
  - start ignored in RUN.
- HALTED: pc and instr_count frozen (readable). start=1 -> RUN, pc=START_ADDR, instr_count=0. stall/halt/branch ignored.
- instr_count saturates at all-ones; never wraps.
- LUT write: in any non-reset cycle, lut_we=1 writes LUT[lut_waddr]=lut_wdata at the edge. Writes allowed in all states.
- Same-cycle write and branch read of the same index: branch uses the old entry; new value visible from next cycle.

## Timing
- All outputs registered; change only on rising clk.
- start sampled at edge N -> pc=START_ADDR, pc_valid=1 after edge N; instruction memory returns instruction combinationally in cycle N+1; decode feedback (halt/branch/stall) sampled at edge N+1.
- Branch latency 1 edge: branch_taken at edge N -> pc=target after edge N; no delay slot, no bubble.
- halt at edge N -> done=1, pc_valid=0 after edge N; pc still shows the halt instruction address.
- reset asserted at edge N mid-run -> all reset values after edge N, LUT included; a start in the same cycle is ignored.

## Test plan
- Reset then start, no stall/branch/halt for 5 cycles -> pc sequence 0,1,2,3,4,5; pc_valid=1; instr_count=5; done=0.
- Load LUT[3]=0x0A0, run, assert branch_taken with branch_idx=3 at pc=2 -> next pc=0x0A0, then 0x0A1; simultaneous lut_we to index 3 with 0x0B0 in that cycle still yields 0x0A0.
- Stall 3 cycles at pc=4 together with branch_taken=1 -> pc stays 4, instr_count unchanged; after release pc=5.
- halt at pc=7 with stall=1 -> HALTED, done=1, pc_valid=0, pc=7, instr_count incremented by 1; later start -> pc=0, instr_count=0, done=0.
- Force pc to 0xFFF via LUT branch, free-run -> pc wraps to 0x000; preset instr_count path with CNT_BITS=4 run 20 instructions -> instr_count holds 15.
- reset asserted mid-run at pc=0x0A1 with start=1 and lut_we=1 -> state IDLE, pc=0, instr_count=0, LUT entry reads 0 on subsequent branch.

Source files
------------

// File: rtl/fetch_pc.sv
// Program counter and fetch sequencing for the instruction memory.
// Runs IDLE -> RUN -> HALTED with a branch-target LUT and an instruction count.
module fetch_pc #(
  parameter int unsigned PC_BITS      = 12,
  parameter int unsigned LUT_IDX_BITS = 3,
  parameter int unsigned CNT_BITS     = 16,
  parameter int unsigned START_ADDR   = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stall,
  input  logic                    halt,
  input  logic                    branch_taken,
  input  logic [LUT_IDX_BITS-1:0] branch_idx,
  input  logic                    lut_we,
  input  logic [LUT_IDX_BITS-1:0] lut_waddr,
  input  logic [PC_BITS-1:0]      lut_wdata,
  output logic [PC_BITS-1:0]      pc,
  output logic                    pc_valid,
  output logic                    done,
  output logic [CNT_BITS-1:0]     instr_count
);

  localparam int unsigned LUT_N = 2 ** LUT_IDX_BITS;
  localparam logic [PC_BITS-1:0] PC_START = PC_BITS'(START_ADDR);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALTED
  } state_e;

  state_e                state_q, state_d;
  logic [PC_BITS-1:0]    pc_q, pc_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic [CNT_BITS-1:0]   cnt_inc;
  logic [PC_BITS-1:0]    lut_q [LUT_N];

  // Counter sticks at all-ones instead of wrapping.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_BITS'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        pc_d = PC_START;
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (halt) begin
          state_d = S_HALTED;
          cnt_d   = cnt_inc;
        end else if (stall) begin
          pc_d  = pc_q;
        end else if (branch_taken) begin
          pc_d  = lut_q[branch_idx];
          cnt_d = cnt_inc;
        end else begin
          pc_d  = pc_q + PC_BITS'(1);
          cnt_d = cnt_inc;
        end
      end
      S_HALTED: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = PC_START;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = PC_START;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= PC_START;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Branch reads see the pre-edge entry; a write lands at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LUT_N; i++) begin
        lut_q[i] <= '0;
      end
    end else if (lut_we) begin
      lut_q[lut_waddr] <= lut_wdata;
    end
  end

  assign pc          = pc_q;
  assign pc_valid    = (state_q == S_RUN);
  assign done        = (state_q == S_HALTED);
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_fetch_pc.sv
// Directed bench for fetch_pc: sequencing, branch LUT, stall, halt,
// wrap, counter saturation and mid-run reset.
module tb_fetch_pc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        branch_taken = 1'b0;
  logic [2:0]  branch_idx = '0;
  logic        lut_we = 1'b0;
  logic [2:0]  lut_waddr = '0;
  logic [11:0] lut_wdata = '0;
  logic [11:0] pc, pc4;
  logic        pc_valid, done, pc_valid4, done4;
  logic [15:0] instr_count;
  logic [3:0]  instr_count4;

  int errors = 0;
  int checks = 0;
  logic [29:0] obs, exp_v;

  fetch_pc dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .halt(halt), .branch_taken(branch_taken), .branch_idx(branch_idx),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .pc(pc), .pc_valid(pc_valid), .done(done),
    .instr_count(instr_count)
  );

  fetch_pc #(.CNT_BITS(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .halt(halt), .branch_taken(branch_taken), .branch_idx(branch_idx),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .pc(pc4), .pc_valid(pc_valid4), .done(done4),
    .instr_count(instr_count4)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    reset = 0; start = 0; stall = 0; halt = 0;
    branch_taken = 0; branch_idx = 0;
    lut_we = 0; lut_waddr = 0; lut_wdata = 0;
  endtask

  task automatic do_reset();
    clear_in();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic lut_write(input logic [2:0] a, input logic [11:0] d);
    lut_we = 1; lut_waddr = a; lut_wdata = d;
    step();
    lut_we = 0;
  endtask

  task automatic test_reset();
    do_reset();
    obs = {pc, pc_valid, done, instr_count};
    exp_v = {12'h000, 1'b0, 1'b0, 16'd0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset_state got=%h want=%h", obs, exp_v);
    end
    step();
    obs = {pc, pc_valid, done, instr_count};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL idle_hold got=%h want=%h", obs, exp_v);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    start = 1;
    step();
    start = 0;
    obs = {pc, pc_valid, done, instr_count};
    exp_v = {12'h000, 1'b1, 1'b0, 16'd0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL start_run got=%h want=%h", obs, exp_v);
    end
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++;
      if (pc !== 12'(i)) begin
        errors++;
        $display("FAIL seq_pc%0d got=%h want=%h", i, pc, 12'(i));
      end
    end
    obs = {pc, pc_valid, done, instr_count};
    exp_v = {12'h005, 1'b1, 1'b0, 16'd5};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL seq_end got=%h want=%h", obs, exp_v);
    end
  endtask

  task automatic test_branch();
    do_reset();
    lut_write(3'd3, 12'h0A0);
    start = 1;
    step();
    start = 0;
    step();
    step();
    branch_taken = 1; branch_idx = 3;
    lut_we = 1; lut_waddr = 3; lut_wdata = 12'h0B0;
    step();
    clear_in();
    obs = {pc, pc_valid, done, instr_count};
    exp_v = {12'h0A0, 1'b1, 1'b0, 16'd3};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL branch_old_entry got=%h want=%h", obs, exp_v);
    end
    step();
    obs = {pc, pc_valid, done, instr_count};
    exp_v = {12'h0A1, 1'b1, 1'b0, 16'd4};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL branch_next got=%h want=%h", obs, exp_v);
    end
    branch_taken = 1; branch_idx = 3;
    step();
    clear_in();
    checks++;
    if (pc !== 12'h0B0) begin
      errors++;
      $display("FAIL branch_new_entry got=%h want=%h", pc, 12'h0B0);
    end
  endtask

  task automatic test_stall();
    do_reset();
    lut_write(3'd2, 12'h333);
    start = 1;
    step();
    start = 0;
    repeat (4) step();
    stall = 1; branch_taken = 1; branch_idx = 2;
    for (int i = 0; i < 3; i++) begin
      step();
      obs = {pc, pc_valid, done, instr_count};
      exp_v = {12'h004, 1'b1, 1'b0, 16'd4};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL stall_hold%0d got=%h want=%h", i, obs, exp_v);
      end
    end
    clear_in();
    step();
    obs = {pc, pc_valid, done, instr_count};
    exp_v = {12'h005, 1'b1, 1'b0, 16'd5};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL stall_release got=%h want=%h", obs, exp_v);
    end
  endtask

  task automatic test_halt();
    step();
    step();
    halt = 1; stall = 1;
    step();
    clear_in();
    obs = {pc, pc_valid, done, instr_count};
    exp_v = {12'h007, 1'b0, 1'b1, 16'd8};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL halt_enter got=%h want=%h", obs, exp_v);
    end
    halt = 1; branch_taken = 1; branch_idx = 2;
    step();
    step();
    clear_in();
    obs = {pc, pc_valid, done, instr_count};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL halt_frozen got=%h want=%h", obs, exp_v);
    end
    start = 1;
    step();
    start = 0;
    obs = {pc, pc_valid, done, instr_count};
    exp_v = {12'h000, 1'b1, 1'b0, 16'd0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL halt_restart got=%h want=%h", obs, exp_v);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    lut_write(3'd5, 12'hFFF);
    start = 1;
    step();
    start = 0;
    branch_taken = 1; branch_idx = 5;
    step();
    clear_in();
    checks++;
    if (pc !== 12'hFFF) begin
      errors++;
      $display("FAIL wrap_target got=%h want=%h", pc, 12'hFFF);
    end
    step();
    obs = {pc, pc_valid, done, instr_count};
    exp_v = {12'h000, 1'b1, 1'b0, 16'd2};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL wrap_zero got=%h want=%h", obs, exp_v);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    start = 1;
    step();
    start = 0;
    repeat (14) step();
    checks++;
    if (instr_count4 !== 4'd14) begin
      errors++;
      $display("FAIL sat_pre got=%0d want=14", instr_count4);
    end
    repeat (6) step();
    checks++;
    if (instr_count4 !== 4'd15) begin
      errors++;
      $display("FAIL sat_hold got=%0d want=15", instr_count4);
    end
    checks++;
    if (instr_count !== 16'd20) begin
      errors++;
      $display("FAIL cnt16_20 got=%0d want=20", instr_count);
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    lut_write(3'd3, 12'h0A0);
    start = 1;
    step();
    start = 0;
    branch_taken = 1; branch_idx = 3;
    step();
    clear_in();
    step();
    checks++;
    if (pc !== 12'h0A1) begin
      errors++;
      $display("FAIL mid_pre got=%h want=%h", pc, 12'h0A1);
    end
    reset = 1; start = 1;
    lut_we = 1; lut_waddr = 4; lut_wdata = 12'h123;
    step();
    clear_in();
    obs = {pc, pc_valid, done, instr_count};
    exp_v = {12'h000, 1'b0, 1'b0, 16'd0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL mid_reset got=%h want=%h", obs, exp_v);
    end
    step();
    obs = {pc, pc_valid, done, instr_count};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL mid_idle got=%h want=%h", obs, exp_v);
    end
    start = 1;
    step();
    start = 0;
    step();
    branch_taken = 1; branch_idx = 3;
    step();
    clear_in();
    checks++;
    if (pc !== 12'h000) begin
      errors++;
      $display("FAIL lut3_cleared got=%h want=%h", pc, 12'h000);
    end
    step();
    branch_taken = 1; branch_idx = 4;
    step();
    clear_in();
    checks++;
    if (pc !== 12'h000) begin
      errors++;
      $display("FAIL lut4_no_write got=%h want=%h", pc, 12'h000);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_halt();
    test_wrap();
    test_saturate();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
